// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory responder and the fetch stage.
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } imem_state_t;

    // The fetch stage's reset PC points at IMEM_BASE_ADDR, so keep these in sync.
    localparam logic [15:0] IMEM_BASE_ADDR = 16'h3000;
    localparam int          IMEM_DEPTH     = 256;
    localparam int          MAX_WAIT       = 15;
    localparam int          CNT_W          = 4;

endpackage

// File: rtl/imem_array.sv
// Word storage: one synchronous preload write port, one synchronous read port
// whose register returns the pre-write contents when both hit the same word.
module imem_array #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic              rd_hit,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rd_data_r;

    // Preload write port; storage is deliberately left untouched by reset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_r[wr_idx] <= wr_data;
        end
    end

    // Read register: a miss (out-of-range request) returns zero and holds until the next read.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_data_r <= {DATA_W{1'b0}};
        end else if (rd_en) begin
            rd_data_r <= rd_hit ? mem_r[rd_idx] : {DATA_W{1'b0}};
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/instr_mem_responder.sv
// Responder side of the fetch/instruction-memory handshake: accepts a PC,
// waits WAIT_STATES cycles, then pulses complete with the word (or an address error).
module instr_mem_responder
    import imem_pkg::*;
#(
    parameter int                ADDR_W      = 16,
    parameter int                DATA_W      = 16,
    parameter int                DEPTH       = IMEM_DEPTH,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(IMEM_BASE_ADDR),
    parameter int                WAIT_STATES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    input  logic              instrmem_rd,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] dout,
    output logic              complete,
    output logic              addr_err
);

    localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                AW1       = ADDR_W + 1;
    localparam logic [AW1-1:0]    DEPTH_EXT = AW1'(DEPTH);
    localparam logic [CNT_W-1:0]  WAIT_INIT = CNT_W'(WAIT_STATES);

    // Offset from BASE_ADDR wraps modulo 2^ADDR_W, so the lower bound is checked separately.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] off;
        off = addr - BASE_ADDR;
        return (addr >= BASE_ADDR) && ({1'b0, off} < DEPTH_EXT);
    endfunction

    function automatic logic [IDX_W-1:0] addr_to_idx(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] off;
        off = addr - BASE_ADDR;
        return off[IDX_W-1:0];
    endfunction

    imem_state_t       state_r, state_nx_s;
    logic [CNT_W-1:0]  cnt_r, cnt_nx_s;
    logic [ADDR_W-1:0] req_addr_r, req_addr_nx_s;
    logic              complete_r, complete_nx_s;
    logic              addr_err_r, addr_err_nx_s;
    logic              req_s;
    logic              req_hit_s;
    logic              rd_en_s;
    logic              we_s;
    logic [DATA_W-1:0] rd_data_s;

    // Fetch floats the strobe when idle; a z must never look like a request.
    assign req_s     = (instrmem_rd === 1'b1);
    assign req_hit_s = addr_in_range(req_addr_r);
    assign we_s      = load_en && addr_in_range(load_addr);

    // Next-state, wait counter and response flag logic.
    always_comb begin
        state_nx_s    = state_r;
        cnt_nx_s      = cnt_r;
        req_addr_nx_s = req_addr_r;
        complete_nx_s = complete_r;
        addr_err_nx_s = addr_err_r;
        rd_en_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_s) begin
                    state_nx_s    = BUSY;
                    req_addr_nx_s = pc;
                    cnt_nx_s      = WAIT_INIT;
                end else begin
                    state_nx_s    = IDLE;
                end
            end
            BUSY: begin
                if (cnt_r != 4'd0) begin
                    cnt_nx_s      = cnt_r - 4'd1;
                end else begin
                    rd_en_s       = 1'b1;
                    complete_nx_s = 1'b1;
                    addr_err_nx_s = !req_hit_s;
                    state_nx_s    = RESP;
                end
            end
            RESP: begin
                complete_nx_s = 1'b0;
                addr_err_nx_s = 1'b0;
                if (req_s) begin
                    state_nx_s    = BUSY;
                    req_addr_nx_s = pc;
                    cnt_nx_s      = WAIT_INIT;
                end else begin
                    state_nx_s    = IDLE;
                end
            end
            default: begin
                state_nx_s    = IDLE;
                cnt_nx_s      = 4'd0;
                complete_nx_s = 1'b0;
                addr_err_nx_s = 1'b0;
            end
        endcase
    end

    // State and control registers; an asserted reset drops any pending request.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            cnt_r      <= 4'd0;
            req_addr_r <= {ADDR_W{1'b0}};
            complete_r <= 1'b0;
            addr_err_r <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            cnt_r      <= cnt_nx_s;
            req_addr_r <= req_addr_nx_s;
            complete_r <= complete_nx_s;
            addr_err_r <= addr_err_nx_s;
        end
    end

    imem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (we_s),
        .wr_idx  (addr_to_idx(load_addr)),
        .wr_data (load_data),
        .rd_en   (rd_en_s),
        .rd_hit  (req_hit_s),
        .rd_idx  (addr_to_idx(req_addr_r)),
        .rd_data (rd_data_s)
    );

    assign dout     = rd_data_s;
    assign complete = complete_r;
    assign addr_err = addr_err_r;

endmodule

// File: doc/instr_mem_responder.md
# instr_mem_responder

- Responder end of the fetch-to-instruction-memory interface.
- Accepts a read request (`pc` plus `instrmem_rd`) from the fetch stage and returns the instruction word after a programmable number of wait states.
- Signals data valid with a one-cycle `complete` pulse and flags out-of-range addresses.
- Holds its own word-addressed storage, with a side load port the bench and boot logic use to preload programs.

## Interface

Parameters:

- `ADDR_W`, 16, address and `pc` width
- `DATA_W`, 16, instruction word width
- `DEPTH`, 256, number of storage words
- `BASE_ADDR`, 16'h3000, address mapped to storage word 0
- `WAIT_STATES`, 2, extra cycles between accept and response (0..15)

Ports:

- `clock`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `pc`  in  ADDR_W  fetch address, sampled only on accept
- `instrmem_rd`  in  1  request; driven 1 or z by fetch, only `=== 1'b1` counts as a request
- `load_en`  in  1  preload write strobe
- `load_addr`  in  ADDR_W  preload address (absolute, same map as `pc`)
- `load_data`  in  DATA_W  preload word
- `dout`  out  DATA_W  instruction word, valid while `complete` is 1 and held afterwards
- `complete`  out  1  one-cycle response pulse
- `addr_err`  out  1  high with `complete` when the accepted address was out of range

## Operation

- States:
  - IDLE: ready.
  - BUSY: counting wait states.
  - RESP: `complete` high.
- Accept:
  - A request is accepted at a rising edge in IDLE or RESP when `instrmem_rd === 1'b1`.
  - On accept, latch `pc` into `req_addr`, load `cnt = WAIT_STATES`, go to BUSY.
  - `pc` changes during BUSY are ignored.
- BUSY:
  - If `cnt != 0`, decrement `cnt`.
  - If `cnt == 0`, at that edge register `dout`, set `complete` to 1 and `addr_err`, and go to RESP.
- RESP:
  - Lasts exactly one cycle.
  - At its closing edge, either accept a new request (go to BUSY) or clear `complete` and go to IDLE.
- Range check:
  - `idx = req_addr - BASE_ADDR`, computed modulo 2^ADDR_W.
  - In range iff `req_addr >= BASE_ADDR` and `idx < DEPTH`.
  - Out of range gives `dout = 0` and `addr_err = 1`; no storage access.
- Preload:
  - When `load_en` is high at an edge and `load_addr` is in range, write `load_data`. Out-of-range loads are dropped silently.
  - Loads are legal in any state.
  - If a load and the response read hit the same word at the same edge, `dout` gets the old contents (read-before-write).
- `instrmem_rd` deasserted or z during BUSY does not cancel the transaction; the response still completes.
- Reset, async assert, mid-transaction:
  - State goes to IDLE, `cnt` = 0, `dout` = 0, `complete` = 0, `addr_err` = 0.
  - The pending request is discarded.
  - Storage contents are not cleared.

## Timing

- Reset values: `dout` = 16'h0000, `complete` = 0, `addr_err` = 0, state IDLE.
- Latency: accept at edge E0 gives `complete` high from edge E(WAIT_STATES+1) to E(WAIT_STATES+2).
  - `WAIT_STATES = 0` gives `complete` in the cycle immediately after accept.
- Throughput: with `instrmem_rd` held high, one response every `WAIT_STATES+2` cycles, with no idle cycle between RESP and the next BUSY.
- All outputs are registered; there is no combinational path from inputs to outputs.
- `dout` holds its last value until the next response edge.

## Structure

- Package `imem_pkg`:
  - state enum `imem_state_t` {IDLE, BUSY, RESP}
  - default `BASE_ADDR` and `DEPTH` constants, shared with the fetch stage's reset PC
  - `MAX_WAIT` = 15
- Sub-module `imem_array`:
  - `DEPTH x DATA_W` storage
  - one synchronous write port (preload)
  - one synchronous read port with read-before-write
- The top level holds the FSM, wait counter, range check and output registers.

## Test plan

- Reset then preload:
  - Stimulus: `reset` low, then release; load 16'h1234 at 16'h3000; `pc` = 16'h3000 with `instrmem_rd` = 1 for one cycle, `WAIT_STATES` = 2.
  - Required: `complete` is a single pulse exactly 3 edges after accept, with `dout` = 16'h1234 and `addr_err` = 0.
- Back-to-back fetch:
  - Stimulus: `instrmem_rd` held 1 while `pc` steps 16'h3000, 16'h3001, 16'h3002 on each accept.
  - Required: three pulses spaced 4 cycles apart, returning the preloaded words in order.
- Range boundaries, `DEPTH` = 256:
  - `pc` = 16'h2FFF gives `addr_err` = 1 and `dout` = 0.
  - `pc` = 16'h30FF is valid.
  - `pc` = 16'h3100 gives `addr_err` = 1.
- Mid-transaction events:
  - Changing `pc` and floating `instrmem_rd` to z during BUSY: the response uses the latched address.
  - Asserting `reset` during BUSY: no `complete`, all outputs 0, and storage is intact on the next read.
- `WAIT_STATES` = 0, with a same-edge load to the word being read:
  - `complete` comes 1 edge after accept.
  - `dout` is the old word; the following read returns the new word.
